// File: rtl/uart_tx_capture_pkg.sv
// Shared constants and FIFO entry layout for the transmit-byte capture block.
// An entry packs {chan, data, last} with last in the LSB.
package uart_tx_capture_pkg;

  localparam logic [7:0] EOL_DEFAULT = 8'h0A;

  localparam int ENT_LAST_OFS = 0;
  localparam int ENT_DATA_OFS = 1;

  function automatic int ch_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  function automatic int ent_chan_ofs(input int data_w);
    return ENT_DATA_OFS + data_w;
  endfunction

  function automatic int ent_width(input int data_w, input int ch_w);
    return 1 + data_w + ch_w;
  endfunction

endpackage

// File: rtl/uart_tx_capture_sync_fifo.sv
// Single-clock FIFO with registered storage and an extra wrap bit on each pointer.
// A push is accepted while full when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [AW:0]      level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_tx_capture.sv
// Captures one byte per busy episode from each transmitter, parks it in a pending
// register, and merges pending bytes round-robin into a tagged FIFO stream.
module uart_tx_capture
  import uart_tx_capture_pkg::*;
#(
  parameter int         CHANNELS  = 2,
  parameter int         DATA_W    = 8,
  parameter int         DEPTH     = 16,
  parameter int         LINE_MODE = 0,
  parameter logic [7:0] EOL       = EOL_DEFAULT,
  parameter int         OVF_W     = 16,
  localparam int        CH_W      = ch_width(CHANNELS),
  localparam int        LVL_W     = $clog2(DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic [CHANNELS-1:0]        ch_busy,
  input  logic [CHANNELS*DATA_W-1:0] ch_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [CH_W-1:0]            out_chan,
  output logic                       out_last,
  output logic [OVF_W-1:0]           ovf_count,
  output logic [LVL_W-1:0]           fifo_level
);

  localparam int CHAN_OFS = ent_chan_ofs(DATA_W);
  localparam int ENT_W    = ent_width(DATA_W, CH_W);

  logic [CHANNELS-1:0] armed_q, armed_d;
  logic [CHANNELS-1:0] pend_v_q, pend_v_d;
  logic [DATA_W-1:0]   pend_data_q [CHANNELS];
  logic [DATA_W-1:0]   pend_data_d [CHANNELS];
  logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [OVF_W-1:0]    ovf_q, ovf_d;

  logic [CHANNELS-1:0] grant;
  logic                grant_any;
  logic [CH_W-1:0]     grant_idx;
  logic [DATA_W-1:0]   sel_data;
  logic                sel_last;
  logic [ENT_W-1:0]    push_entry, head_entry;
  logic                fifo_full, fifo_empty, pop;

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  // Search starts at rr_ptr and wraps; granting is allowed only if the FIFO can take it.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    sel_data  = '0;
    if (!clear && (!fifo_full || pop)) begin
      for (int i = 0; i < CHANNELS; i++) begin
        idx = int'(rr_ptr_q) + i;
        if (idx >= CHANNELS) idx = idx - CHANNELS;
        if (!grant_any && pend_v_q[idx]) begin
          grant_any  = 1'b1;
          grant[idx] = 1'b1;
          grant_idx  = CH_W'(idx);
          sel_data   = pend_data_q[idx];
        end
      end
    end
  end

  assign sel_last = (LINE_MODE != 0) && (sel_data[7:0] == EOL);

  always_comb begin
    push_entry                         = '0;
    push_entry[ENT_LAST_OFS]           = sel_last;
    push_entry[ENT_DATA_OFS +: DATA_W] = sel_data;
    push_entry[CHAN_OFS +: CH_W]       = grant_idx;
  end

  always_comb begin
    armed_d     = armed_q;
    pend_v_d    = pend_v_q;
    pend_data_d = pend_data_q;
    rr_ptr_d    = rr_ptr_q;
    ovf_d       = ovf_q;
    if (clear) begin
      armed_d  = '0;
      pend_v_d = '0;
      rr_ptr_d = '0;
      ovf_d    = '0;
    end else begin
      if (grant_any)
        rr_ptr_d = (grant_idx == CH_W'(CHANNELS - 1)) ? '0 : grant_idx + CH_W'(1);
      for (int k = 0; k < CHANNELS; k++) begin
        if (grant[k]) pend_v_d[k] = 1'b0;
        if (!ch_busy[k]) begin
          armed_d[k] = 1'b1;
        end else if (armed_q[k]) begin
          armed_d[k] = 1'b0;
          // A register being drained this cycle can take the new byte without loss.
          if (pend_v_q[k] && !grant[k]) begin
            if (ovf_d != '1) ovf_d = ovf_d + OVF_W'(1);
          end else begin
            pend_v_d[k]    = 1'b1;
            pend_data_d[k] = ch_data[k*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed_q  <= '0;
      pend_v_q <= '0;
      rr_ptr_q <= '0;
      ovf_q    <= '0;
      for (int k = 0; k < CHANNELS; k++) pend_data_q[k] <= '0;
    end else begin
      armed_q     <= armed_d;
      pend_v_q    <= pend_v_d;
      rr_ptr_q    <= rr_ptr_d;
      ovf_q       <= ovf_d;
      pend_data_q <= pend_data_d;
    end
  end

  sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .clear_i     (clear),
    .push_i      (grant_any),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head_entry),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .level_o     (fifo_level)
  );

  assign out_data  = head_entry[ENT_DATA_OFS +: DATA_W];
  assign out_chan  = head_entry[CHAN_OFS +: CH_W];
  assign out_last  = (LINE_MODE != 0) && head_entry[ENT_LAST_OFS];
  assign ovf_count = ovf_q;

endmodule

// File: tb/tb_uart_tx_capture.sv
// Directed bench: four instances in different configurations, one linear stimulus sequence.
module tb_uart_tx_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;

  // a: CHANNELS=1 (single byte, busy at reset)
  logic       a_busy, a_ready, a_valid, a_chan, a_last;
  logic [7:0] a_data_i, a_data;
  logic [15:0] a_ovf;
  logic [4:0] a_level;
  // b: CHANNELS=4 (simultaneous start)
  logic [3:0]  b_busy;
  logic [31:0] b_data_i;
  logic        b_ready, b_valid, b_last;
  logic [7:0]  b_data;
  logic [1:0]  b_chan;
  logic [15:0] b_ovf;
  logic [4:0]  b_level;
  // c: DEPTH=4 (full FIFO, clear)
  logic [1:0]  c_busy;
  logic [15:0] c_data_i;
  logic        c_clear, c_ready, c_valid, c_chan, c_last;
  logic [7:0]  c_data;
  logic [15:0] c_ovf;
  logic [2:0]  c_level;
  // d: LINE_MODE=1
  logic        d_busy, d_ready, d_valid, d_chan, d_last;
  logic [7:0]  d_data_i, d_data;
  logic [15:0] d_ovf;
  logic [4:0]  d_level;

  uart_tx_capture #(.CHANNELS(1)) u_a (
    .clk(clk), .reset(rst_n), .clear(1'b0), .ch_busy(a_busy), .ch_data(a_data_i),
    .out_valid(a_valid), .out_ready(a_ready), .out_data(a_data), .out_chan(a_chan),
    .out_last(a_last), .ovf_count(a_ovf), .fifo_level(a_level));

  uart_tx_capture #(.CHANNELS(4)) u_b (
    .clk(clk), .reset(rst_n), .clear(1'b0), .ch_busy(b_busy), .ch_data(b_data_i),
    .out_valid(b_valid), .out_ready(b_ready), .out_data(b_data), .out_chan(b_chan),
    .out_last(b_last), .ovf_count(b_ovf), .fifo_level(b_level));

  uart_tx_capture #(.DEPTH(4)) u_c (
    .clk(clk), .reset(rst_n), .clear(c_clear), .ch_busy(c_busy), .ch_data(c_data_i),
    .out_valid(c_valid), .out_ready(c_ready), .out_data(c_data), .out_chan(c_chan),
    .out_last(c_last), .ovf_count(c_ovf), .fifo_level(c_level));

  uart_tx_capture #(.CHANNELS(1), .LINE_MODE(1)) u_d (
    .clk(clk), .reset(rst_n), .clear(1'b0), .ch_busy(d_busy), .ch_data(d_data_i),
    .out_valid(d_valid), .out_ready(d_ready), .out_data(d_data), .out_chan(d_chan),
    .out_last(d_last), .ovf_count(d_ovf), .fifo_level(d_level));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic c_pulse(input logic [7:0] v);
    c_busy   = 2'b01;
    c_data_i = {8'h00, v};
    tick(1);
    c_busy   = 2'b00;
    tick(1);
  endtask

  task automatic d_pulse(input logic [7:0] v);
    d_busy   = 1'b1;
    d_data_i = v;
    tick(1);
    d_busy   = 1'b0;
    tick(1);
  endtask

  initial begin
    rst_n   = 1'b0;
    a_busy  = 1'b1; a_data_i = 8'h55; a_ready = 1'b0;
    b_busy  = '0;   b_data_i = '0;    b_ready = 1'b0;
    c_busy  = '0;   c_data_i = '0;    c_ready = 1'b0; c_clear = 1'b0;
    d_busy  = 1'b0; d_data_i = '0;    d_ready = 1'b0;
    tick(3);

    check("rst_a_valid", a_valid, 0);
    check("rst_a_data",  a_data,  0);
    check("rst_a_chan",  a_chan,  0);
    check("rst_a_level", a_level, 0);
    check("rst_c_ovf",   c_ovf,   0);
    check("rst_d_last",  d_last,  0);
    check("rst_b_valid", b_valid, 0);
    rst_n = 1'b1;

    // busy held high through reset release must not be captured
    tick(4);
    check("busy_rst_valid", a_valid, 0);
    check("busy_rst_level", a_level, 0);
    a_busy = 1'b0;
    tick(1);
    a_busy = 1'b1; a_data_i = 8'h41;
    tick(1);
    check("single_e0_valid", a_valid, 0);
    tick(1);
    check("single_e1_valid", a_valid, 1);
    check("single_data",     a_data,  8'h41);
    check("single_chan",     a_chan,  0);
    tick(48);
    check("single_level", a_level, 1);
    a_busy = 1'b0; a_ready = 1'b1;
    tick(1);
    check("single_drained", a_valid, 0);
    a_ready = 1'b0;

    // simultaneous start on four channels
    b_busy = 4'hF; b_data_i = {8'h13, 8'h12, 8'h11, 8'h10}; b_ready = 1'b1;
    tick(1);
    check("rr_e0_valid", b_valid, 0);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("rr_valid", b_valid, 1);
      check("rr_chan",  b_chan,  i);
      check("rr_data",  b_data,  8'h10 + i);
      if (i == 0) check("rr_ptr_mid", u_b.rr_ptr_q, 1);
    end
    check("rr_ptr_end", u_b.rr_ptr_q, 0);
    tick(1);
    check("rr_empty", b_valid, 0);
    check("rr_ovf",   b_ovf,   0);
    b_busy = '0; b_ready = 1'b0;

    // full FIFO: four queued, one pending, one dropped
    tick(1);
    c_pulse(8'hA1); c_pulse(8'hA2); c_pulse(8'hA3);
    c_pulse(8'hA4); c_pulse(8'hA5); c_pulse(8'hA6);
    check("full_level", c_level, 4);
    check("full_ovf",   c_ovf,   1);
    check("full_head",  c_data,  8'hA1);
    c_ready = 1'b1; c_busy = 2'b01; c_data_i = 16'h00A7;
    tick(1);
    c_ready = 1'b0; c_busy = 2'b00;
    tick(1);
    check("popcap_level", c_level, 4);
    check("popcap_ovf",   c_ovf,   1);
    check("popcap_head",  c_data,  8'hA2);
    c_pulse(8'hB1); c_pulse(8'hB2); c_pulse(8'hB3); c_pulse(8'hB4);
    check("drops_ovf", c_ovf, 5);
    c_ready = 1'b1;
    tick(2);
    c_ready = 1'b0;
    check("pre_clr_level", c_level, 3);
    check("pre_clr_head",  c_data,  8'hA4);
    c_clear = 1'b1;
    tick(1);
    c_clear = 1'b0;
    check("clr_valid", c_valid, 0);
    check("clr_level", c_level, 0);
    check("clr_ovf",   c_ovf,   0);
    // clear disarms: the first busy pulse straight after it is ignored
    c_pulse(8'hC1);
    tick(1);
    check("clr_disarm_level", c_level, 0);
    c_pulse(8'hC2);
    check("clr_rearm_level", c_level, 1);
    check("clr_rearm_data",  c_data,  8'hC2);

    // line mode tagging
    d_pulse(8'h6F); d_pulse(8'h6B); d_pulse(8'h0A);
    check("line_level", d_level, 3);
    check("line_data0", d_data,  8'h6F);
    check("line_last0", d_last,  0);
    d_ready = 1'b1; tick(1); d_ready = 1'b0;
    check("line_data1", d_data, 8'h6B);
    check("line_last1", d_last, 0);
    d_ready = 1'b1; tick(1); d_ready = 1'b0;
    check("line_data2", d_data, 8'h0A);
    check("line_last2", d_last, 1);

    // asynchronous reset discards state without a clock edge
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", c_valid, 0);
    check("async_rst_level", d_level, 0);
    tick(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
